// File: rtl/aes_req_sched.sv
// aes_req_sched: round-robin, credit-limited scheduler sharing one fixed-latency AES-128 core.
// Define AES_REQ_SCHED_PERF_EN to add the perf_issued / perf_stall counters.
`timescale 1ns/1ps
module aes_req_sched #(
  parameter int NREQ       = 2,
  parameter int AES_LAT    = 21,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NREQ-1:0]                          req_valid,
  output logic [NREQ-1:0]                          req_ready,
  input  logic [NREQ*128-1:0]                      req_state,
  input  logic [NREQ*128-1:0]                      req_key,
  input  logic                                     flush,
  output logic [127:0]                             aes_state,
  output logic [127:0]                             aes_key,
  input  logic [127:0]                             aes_out,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [((NREQ > 2) ? $clog2(NREQ) : 1)-1:0] rsp_id,
  output logic [127:0]                             rsp_data,
  output logic                                     busy
`ifdef AES_REQ_SCHED_PERF_EN
  ,
  output logic [31:0]                              perf_issued,
  output logic [31:0]                              perf_stall
`endif
);

  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int IFW = $clog2(AES_LAT + 1);
  localparam int SW  = ((IFW > CW) ? IFW : CW) + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            r_state;
  logic [IDW-1:0]    r_rrPtr;
  logic [127:0]      r_aesState;
  logic [127:0]      r_aesKey;
  logic [AES_LAT-1:0] r_tagValid;
  logic [IDW-1:0]    r_tagId [AES_LAT];
  logic [IFW-1:0]    r_inflight;
  logic [CW-1:0]     r_count;
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [127:0]      r_fifoData [FIFO_DEPTH];
  logic [IDW-1:0]    r_fifoId [FIFO_DEPTH];

  logic [SW-1:0]     w_occupancy;
  logic              w_canIssue;
  logic              w_found;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_grantIdx;
  logic [IDW-1:0]    w_nextPtr;
  logic [127:0]      w_selState;
  logic [127:0]      w_selKey;
  logic              w_push;
  logic              w_pop;

  // In-flight plus buffered results may never exceed the FIFO, so a push always has room.
  assign w_occupancy = SW'(r_inflight) + SW'(r_count);
  assign w_canIssue  = rst && (r_state == RUN) && !flush && (w_occupancy < SW'(FIFO_DEPTH));

  always_comb begin
    w_grant    = '0;
    w_grantIdx = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_canIssue && req_valid[i] && (i >= int'(r_rrPtr))) begin
        w_found    = 1'b1;
        w_grantIdx = IDW'(i);
        w_grant[i] = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && w_canIssue && req_valid[i]) begin
        w_found    = 1'b1;
        w_grantIdx = IDW'(i);
        w_grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_selState = '0;
    w_selKey   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_selState = req_state[128*i +: 128];
        w_selKey   = req_key[128*i +: 128];
      end
    end
  end

  assign w_nextPtr = (w_grantIdx == IDW'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;
  assign w_push    = r_tagValid[AES_LAT-1];
  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;

  assign req_ready = w_grant;
  assign aes_state = r_aesState;
  assign aes_key   = r_aesKey;
  assign rsp_id    = rsp_valid ? r_fifoId[r_rdPtr] : '0;
  assign rsp_data  = rsp_valid ? r_fifoData[r_rdPtr] : '0;
  assign busy      = (r_inflight != '0) || rsp_valid || (r_state == DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (flush) r_state <= DRAIN;
        DRAIN:   if (!flush && (r_inflight == '0)) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrPtr    <= '0;
      r_aesState <= '0;
      r_aesKey   <= '0;
      r_tagValid <= '0;
      for (int i = 0; i < AES_LAT; i++) r_tagId[i] <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
    end else begin
      if (w_found) begin
        r_aesState <= w_selState;
        r_aesKey   <= w_selKey;
        r_rrPtr    <= w_nextPtr;
      end
      // Tag pipe tracks the core exactly; its last stage marks aes_out as valid.
      r_tagValid <= {r_tagValid[AES_LAT-2:0], w_found};
      r_tagId[0] <= w_grantIdx;
      for (int i = 1; i < AES_LAT; i++) r_tagId[i] <= r_tagId[i-1];
      case ({w_found, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoData[r_wrPtr] <= aes_out;
      r_fifoId[r_wrPtr]   <= r_tagId[AES_LAT-1];
    end
  end

`ifdef AES_REQ_SCHED_PERF_EN
  logic [31:0] r_perfIssued;
  logic [31:0] r_perfStall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perfIssued <= '0;
      r_perfStall  <= '0;
    end else begin
      if (w_found) r_perfIssued <= r_perfIssued + 1'b1;
      if ((|req_valid) && !w_found) r_perfStall <= r_perfStall + 1'b1;
    end
  end

  assign perf_issued = r_perfIssued;
  assign perf_stall  = r_perfStall;
`endif

endmodule
